// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one pipelined 4-operand adder among NREQ requesters.
// Tracks in-flight operations with a tag pipeline and returns each sum to its requester.
module adder_sched #(
    parameter int unsigned DSIZE   = 64,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = $clog2(NREQ),
    parameter int unsigned ADD_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_mask,
    input  logic [NREQ*DSIZE-1:0] req_a,
    input  logic [NREQ*DSIZE-1:0] req_b,
    input  logic [NREQ*DSIZE-1:0] req_c,
    input  logic [NREQ*DSIZE-1:0] req_d,
    output logic [NREQ-1:0]       req_ready,
    output logic [DSIZE-1:0]      add_a,
    output logic [DSIZE-1:0]      add_b,
    output logic [DSIZE-1:0]      add_c,
    output logic [DSIZE-1:0]      add_d,
    input  logic [DSIZE-1:0]      add_sum,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [DSIZE-1:0]      rsp_sum,
    output logic                  busy
);

    localparam int unsigned NSTG = ADD_LAT + 1;
    localparam int unsigned PW   = IDW + 1;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]  elig, grant;
    logic             accept;
    logic [IDW-1:0]   gid;
    logic [PW-1:0]    idx;
    logic [IDW-1:0]   cand;

    logic [DSIZE-1:0] add_a_q, add_a_d;
    logic [DSIZE-1:0] add_b_q, add_b_d;
    logic [DSIZE-1:0] add_c_q, add_c_d;
    logic [DSIZE-1:0] add_d_q, add_d_d;

    logic [NSTG-1:0]          tag_v_q, tag_v_d;
    logic [NSTG-1:0][IDW-1:0] tag_id_q, tag_id_d;

    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [DSIZE-1:0] rsp_sum_q, rsp_sum_d;

    logic [DSIZE-1:0] op_a [NREQ];
    logic [DSIZE-1:0] op_b [NREQ];
    logic [DSIZE-1:0] op_c [NREQ];
    logic [DSIZE-1:0] op_d [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_a[g] = req_a[g*DSIZE +: DSIZE];
        assign op_b[g] = req_b[g*DSIZE +: DSIZE];
        assign op_c[g] = req_c[g*DSIZE +: DSIZE];
        assign op_d[g] = req_d[g*DSIZE +: DSIZE];
    end

    // Search eligible requesters starting at ptr_q, wrapping past NREQ-1.
    always_comb begin
        elig   = req_valid & req_mask;
        grant  = '0;
        gid    = '0;
        accept = 1'b0;
        idx    = '0;
        cand   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + PW'(k);
            if (idx >= PW'(NREQ)) begin
                idx = idx - PW'(NREQ);
            end
            cand = idx[IDW-1:0];
            if (!accept && elig[cand]) begin
                accept      = 1'b1;
                gid         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        ptr_d   = ptr_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        add_c_d = add_c_q;
        add_d_d = add_d_q;
        if (accept) begin
            ptr_d   = (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
            add_a_d = op_a[gid];
            add_b_d = op_b[gid];
            add_c_d = op_c[gid];
            add_d_d = op_d[gid];
        end
    end

    // Stage 0 always loads {accept, gid}; the last stage lines up with add_sum.
    always_comb begin
        tag_v_d     = {tag_v_q[NSTG-2:0], accept};
        tag_id_d    = {tag_id_q[NSTG-2:0], gid};
        rsp_valid_d = tag_v_q[NSTG-1];
        rsp_id_d    = tag_id_q[NSTG-1];
        rsp_sum_d   = tag_v_q[NSTG-1] ? add_sum : rsp_sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_c_q     <= '0;
            add_d_q     <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_c_q     <= add_c_d;
            add_d_q     <= add_d_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_c     = add_c_q;
    assign add_d     = add_d_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign busy      = (|tag_v_q) | rsp_valid_q;

endmodule

// File: doc/adder_sched.md
# adder_sched

Round-robin scheduler that shares one pipelined 4-operand adder (`adder_1`, 2-cycle internal latency) among NREQ requesters. It sits between the requesters and the adder. It accepts one request per cycle with a valid/ready handshake and registers the four operands into the adder. It tracks each in-flight operation with a tag pipeline and returns the sum to the originating requester with a one-cycle response pulse.

## Interface
- `DSIZE`, default 64: operand/sum width; must equal the adder's DSIZE.
- `NREQ`, default 4: number of requesters, at least 2.
- `IDW`, default `$clog2(NREQ)`: requester-ID width.
- `ADD_LAT`, default 2: adder latency in clock edges from operand input to registered sum; the tag pipeline depth is ADD_LAT+1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_mask`  in  NREQ  1 = requester eligible; 0 = ignored by the arbiter.
- `req_a`, `req_b`, `req_c`, `req_d`  in  NREQ*DSIZE each  packed operands; requester i occupies bits [i*DSIZE +: DSIZE].
- `req_ready`  out  NREQ  one-hot (or zero) grant, combinational.
- `add_a`, `add_b`, `add_c`, `add_d`  out  DSIZE each  registered operands to the adder's in_a..in_d.
- `add_sum`  in  DSIZE  adder `sum` output.
- `rsp_valid`  out  1  response pulse.
- `rsp_id`  out  IDW  requester ID for the response.
- `rsp_sum`  out  DSIZE  result.
- `busy`  out  1  any operation in flight (tag pipeline or response register).

## Operation
- Eligible set: `E = req_valid & req_mask`.
- Arbiter: round-robin over E, starting at priority pointer `ptr`.
  - `req_ready[i]` = 1 for the first set bit of E at or after `ptr`, with wrap-around from NREQ-1 to 0.
  - `req_ready` is all zero when E = 0.
- Handshake: `req_valid[i] & req_ready[i]` at a rising edge means accepted.
  - `req_ready` depends combinationally on `req_valid`. Requesters must not gate valid on ready.
  - A requester holds valid and operands stable until accepted.
- Pointer update: on an accept by requester g, `ptr <= (g+1) mod NREQ`. With no accept, ptr holds.
- Issue: on accept, the granted requester's operands are registered into `add_a..add_d`. Otherwise `add_*` hold their previous values.
- Tag pipeline: ADD_LAT+1 stages of {valid, id}.
  - Stage 0 loads {accept, g} every edge.
  - The last stage qualifies `add_sum`.
- Response: every edge, `rsp_valid <= last-stage valid`, `rsp_id <= last-stage id`, `rsp_sum <= add_sum`. `rsp_sum` is loaded only when the last-stage valid is 1 and holds otherwise.
- No response backpressure. Requesters always accept `rsp_valid`.
- Arithmetic: the sum is (a+b+c+d) mod 2^DSIZE, computed by the adder. The scheduler passes the value through unchanged.
- Masking a requester after acceptance does not cancel its in-flight operation.
- `busy` = OR of all tag valid bits and `rsp_valid`.

## Timing
- Reset (async assert, sync deassert expected from the system):
  - `ptr` = 0, all tag valids = 0.
  - `add_*` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0, `busy` = 0.
  - `req_ready` follows E with ptr = 0.
- Latency: accept at edge k gives `add_*` valid after edge k. The adder sum is valid after edge k+ADD_LAT. `rsp_valid` is high for exactly the one cycle after edge k+ADD_LAT+1, which is 3 edges for the default.
- Throughput: one accept per cycle. Back-to-back accepts produce back-to-back responses in accept order.
- With all requesters continuously eligible, the grant order is 0,1,…,NREQ-1,0,…; the starvation bound is NREQ-1 cycles.
- Simultaneous events: an accept and a response retire in the same cycle are independent. A mask change takes effect on the same cycle's grant (combinational).
- Reset mid-operation: all in-flight tags are discarded and no response is produced for them. The adder shares `rst_n`, so its pipeline also clears.

## Test plan
- Single request: requester 2 sends a=1, b=2, c=3, d=4, accepted at edge k → `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=10 in the cycle after edge k+3; `busy` drops the following cycle.
- Full contention: all 4 requesters valid for 8 cycles, each requester i sending a=i and b=c=d=0 → grants 0,1,2,3,0,1,2,3; responses follow 3 edges later with matching `rsp_id` and `rsp_sum`=i.
- Pointer/wrap: only requesters 3 and 0 valid, with reset ptr=0 → grants 0,3,0,3. After requester 3 is granted, ptr wraps to 0.
- Mask: all valid, `req_mask`=4'b1010 → only requesters 1 and 3 are granted, alternating; `req_ready[0]` and `req_ready[2]` stay 0.
- Modulo arithmetic: a=b=c=d=2^64-1 → `rsp_sum` = 2^64-4 (0xFFFF_FFFF_FFFF_FFFC).
- Reset mid-flight: accept 3 back-to-back requests, then assert `rst_n`=0 one edge later → all outputs are 0 immediately; no `rsp_valid` occurs after release; the next request is granted to requester 0 first.
